branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Registered successor to the combinational branch-decision logic. Adds signed/unsigned compares,
//  a full condition set, branch-target computation, misprediction detection and saturating statistics.
//  A valid/ready handshake with a one-entry output register sits between the register-read stage
//  and the PC-update / fetch-flush logic of the multicycle CPU.
// PARAMETERS
//  WORD_W  32  operand width (regA/regB)
//  ADDR_W  32  PC / target width
//  OFF_W   16  signed branch offset width, in words
//  CNT_W   16  width of each statistics counter
// PORTS
//  clk           in   1       clock, all state on rising edge
//  rst_n         in   1       reset, asynchronous, active-low
//  in_valid      in   1       request present
//  in_ready      out  1       request accepted this cycle when in_valid && in_ready
//  branch_type   in   3       000 NONE, 001 BEQ, 010 BNE, 011 BLT, 100 BLE, 101 BGT, 110 BGE, 111 JMP
//  is_signed     in   1       1 = two's-complement compare, 0 = unsigned (LT/LE/GT/GE only)
//  reg_a, reg_b  in   WORD_W  compare operands
//  pc            in   ADDR_W  address of the branch instruction
//  offset        in   OFF_W   signed word offset
//  pred_taken    in   1       fetch-stage prediction for this branch
//  kill          in   1       synchronous squash of held and incoming result
//  clear_stats   in   1       synchronous clear of all counters
//  out_valid     out  1       result register holds a valid result
//  out_ready     in   1       consumer accepts result when out_valid && out_ready
//  taken         out  1       branch decision
//  target        out  ADDR_W  pc + 4 + (sign_ext(offset) << 2), mod 2^ADDR_W
//  mispredict    out  1       taken != pred_taken (NONE: taken=0)
//  flush         out  1       one-cycle pulse: registered version of (out_valid && out_ready && mispredict && !kill)
//  cnt_branches  out  CNT_W   accepted results with branch_type != NONE
//  cnt_taken     out  CNT_W   accepted results with taken=1
//  cnt_mispred   out  CNT_W   accepted results with mispredict=1
// BEHAVIOUR
//  - Reset (rst_n=0, any time, asynchronous): out_valid=0, taken=0, target=0, mispredict=0, flush=0,
//    all counters=0. An in-flight result is discarded. in_ready=1 once rst_n is released.
//  - in_ready = !out_valid || out_ready (combinational; full throughput, no bubble).
//  - Accept (in_valid && in_ready && !kill): decision, target and mispredict are computed from the inputs
//    and registered. out_valid=1 next cycle. Latency is 1 clk from accept to out_valid.
//  - Hold: while out_valid && !out_ready, every output stays stable and in_ready=0.
//  - Drain: out_valid && out_ready with no new accept -> out_valid=0 next cycle.
//    Drain together with accept in the same cycle -> new result replaces old, out_valid stays 1.
//  - kill=1: out_valid=0 next cycle. The same-cycle input is not accepted. Counters do not count it.
//    kill overrides accept and drain.
//  - Compare: EQ/NE are bitwise. LT/LE/GT/GE use is_signed to select $signed or unsigned on WORD_W bits.
//    JMP -> taken=1. NONE -> taken=0.
//  - Target is computed for every type, including not-taken. Addition wraps modulo 2^ADDR_W.
//  - Counters: update on each transfer (out_valid && out_ready && !kill) using the held result.
//    They saturate at 2^CNT_W-1 with no wrap. clear_stats has priority over a same-cycle increment.
//    clear_stats does not affect the datapath.
//  - flush is registered: it asserts the cycle after a mispredicting transfer and lasts exactly 1 clk.
// TESTING
//  1 Reset mid-hold: result held with out_ready=0, pulse rst_n low -> out_valid=0 and counters 0
//    immediately. in_ready=1 after release.
//  2 Signed vs unsigned: BLT, reg_a=32'hFFFF_FFFF, reg_b=1 -> taken=1 when is_signed=1, taken=0 when is_signed=0.
//  3 Target wrap: pc=32'hFFFF_FFF8, offset=16'h0001, JMP -> target=32'h0000_0000, taken=1.
//    Also pc=32'h100, offset=-2 -> target=32'hFC.
//  4 Back-pressure: 3 back-to-back BEQ requests, out_ready low for 2 cycles after the first ->
//    in_ready=0 while held. All 3 results are delivered in order, none lost or duplicated.
//  5 Mispredict/flush: BNE with reg_a=reg_b, pred_taken=1, out_ready=1 -> mispredict=1 and a one-cycle
//    flush. cnt_mispred=1, cnt_taken=0, cnt_branches=1. The same case with kill asserted in the
//    transfer cycle -> no flush and no count.
//  6 Saturation/clear: CNT_W=4, 20 taken JMPs -> cnt_taken=15 holds. clear_stats asserted with a
//    transfer -> all counters 0.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - registered branch resolution with target, mispredict and stats
// One-entry output register behind a valid/ready handshake; kill squashes held and incoming work.
module branch_resolve_unit #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 32,
  parameter int OFF_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        branch_type,
  input  logic              is_signed,
  input  logic [WORD_W-1:0] reg_a,
  input  logic [WORD_W-1:0] reg_b,
  input  logic [ADDR_W-1:0] pc,
  input  logic [OFF_W-1:0]  offset,
  input  logic              pred_taken,
  input  logic              kill,
  input  logic              clear_stats,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              taken,
  output logic [ADDR_W-1:0] target,
  output logic              mispredict,
  output logic              flush,
  output logic [CNT_W-1:0]  cnt_branches,
  output logic [CNT_W-1:0]  cnt_taken,
  output logic [CNT_W-1:0]  cnt_mispred
);

  localparam logic [2:0] BT_NONE = 3'b000;
  localparam logic [2:0] BT_BEQ  = 3'b001;
  localparam logic [2:0] BT_BNE  = 3'b010;
  localparam logic [2:0] BT_BLT  = 3'b011;
  localparam logic [2:0] BT_BLE  = 3'b100;
  localparam logic [2:0] BT_BGT  = 3'b101;
  localparam logic [2:0] BT_BGE  = 3'b110;
  localparam logic [2:0] BT_JMP  = 3'b111;

  logic              accept;
  logic              xfer;
  logic              eq;
  logic              lt;
  logic              taken_d;
  logic [ADDR_W-1:0] off_ext;
  logic [ADDR_W-1:0] target_d;
  logic              is_branch_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !kill;
  assign xfer     = out_valid && out_ready && !kill;

  assign eq = (reg_a == reg_b);
  assign lt = is_signed ? ($signed(reg_a) < $signed(reg_b)) : (reg_a < reg_b);

  always_comb begin
    taken_d = 1'b0;
    case (branch_type)
      BT_NONE: taken_d = 1'b0;
      BT_BEQ:  taken_d = eq;
      BT_BNE:  taken_d = !eq;
      BT_BLT:  taken_d = lt;
      BT_BLE:  taken_d = lt || eq;
      BT_BGT:  taken_d = !lt && !eq;
      BT_BGE:  taken_d = !lt;
      BT_JMP:  taken_d = 1'b1;
      default: taken_d = 1'b0;
    endcase
  end

  // Offset counts words: sign-extend to address width, then scale by 4.
  assign off_ext  = {{(ADDR_W-OFF_W){offset[OFF_W-1]}}, offset};
  assign target_d = pc + ADDR_W'(4) + {off_ext[ADDR_W-3:0], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      taken       <= 1'b0;
      target      <= '0;
      mispredict  <= 1'b0;
      is_branch_q <= 1'b0;
    end else if (kill) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      taken       <= taken_d;
      target      <= target_d;
      mispredict  <= taken_d != pred_taken;
      is_branch_q <= branch_type != BT_NONE;
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush <= 1'b0;
    end else begin
      flush <= xfer && mispredict;
    end
  end

  // Statistics reflect the result being handed off, not the one being loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_branches <= '0;
      cnt_taken    <= '0;
      cnt_mispred  <= '0;
    end else if (clear_stats) begin
      cnt_branches <= '0;
      cnt_taken    <= '0;
      cnt_mispred  <= '0;
    end else if (xfer) begin
      if (is_branch_q) cnt_branches <= sat_inc(cnt_branches);
      if (taken)       cnt_taken    <= sat_inc(cnt_taken);
      if (mispredict)  cnt_mispred  <= sat_inc(cnt_mispred);
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [2:0]  branch_type;
  logic        is_signed;
  logic [31:0] reg_a, reg_b, pc;
  logic [15:0] offset;
  logic        pred_taken, kill, clear_stats;
  logic        out_valid, out_ready, taken, mispredict, flush;
  logic [31:0] target;
  logic [3:0]  cnt_branches, cnt_taken, cnt_mispred;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.WORD_W(32), .ADDR_W(32), .OFF_W(16), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .branch_type(branch_type), .is_signed(is_signed), .reg_a(reg_a), .reg_b(reg_b),
    .pc(pc), .offset(offset), .pred_taken(pred_taken), .kill(kill),
    .clear_stats(clear_stats), .out_valid(out_valid), .out_ready(out_ready),
    .taken(taken), .target(target), .mispredict(mispredict), .flush(flush),
    .cnt_branches(cnt_branches), .cnt_taken(cnt_taken), .cnt_mispred(cnt_mispred)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [2:0] bt, input logic sg,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [15:0] off, input logic pt);
    in_valid = v; branch_type = bt; is_signed = sg; reg_a = a; reg_b = b;
    pc = p; offset = off; pred_taken = pt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; kill = 1'b0; clear_stats = 1'b0; out_ready = 1'b0;
    drive(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 16'd0, 1'b0);
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0h expected 0", out_valid); end
    checks++; if (target !== 32'd0) begin errors++; $display("FAIL rst_target: got %0h expected 0", target); end
    checks++; if ({flush, taken, mispredict} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %0h expected 0", {flush, taken, mispredict}); end
    rst_n = 1'b1;
    drive(1'b1, 3'd7, 1'b0, 32'd0, 32'd0, 32'd0, 16'd0, 1'b1);
    out_ready = 1'b1;
    tick();
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    checks++; if ({out_valid, in_ready} !== 2'b10) begin errors++; $display("FAIL hold_state: got %0b expected 10", {out_valid, in_ready}); end
    checks++; if (cnt_taken !== 4'd1) begin errors++; $display("FAIL pre_rst_cnt_taken: got %0d expected 1", cnt_taken); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midhold_rst_valid: got %0h expected 0", out_valid); end
    checks++; if ({cnt_branches, cnt_taken, cnt_mispred} !== 12'd0) begin errors++; $display("FAIL midhold_rst_cnt: got %0h expected 0", {cnt_branches, cnt_taken, cnt_mispred}); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %0h expected 1", in_ready); end
  endtask

  task automatic test_signed();
    out_ready = 1'b1;
    drive(1'b1, 3'd3, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 16'd0, 1'b0);
    tick();
    checks++; if ({out_valid, taken, mispredict} !== 3'b111) begin errors++; $display("FAIL blt_signed: got %0b expected 111", {out_valid, taken, mispredict}); end
    is_signed = 1'b0;
    tick();
    checks++; if ({out_valid, taken, mispredict} !== 3'b100) begin errors++; $display("FAIL blt_unsigned: got %0b expected 100", {out_valid, taken, mispredict}); end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %0h expected 0", out_valid); end
  endtask

  task automatic test_conditions();
    logic [68:0] vec [12];
    logic [68:0] e;
    vec = '{ {3'd1, 1'b0, 32'd5, 32'd5, 1'b1},
             {3'd1, 1'b0, 32'd5, 32'd6, 1'b0},
             {3'd2, 1'b0, 32'd5, 32'd6, 1'b1},
             {3'd4, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 1'b1},
             {3'd4, 1'b0, 32'd7, 32'd3, 1'b0},
             {3'd5, 1'b1, 32'd1, 32'hFFFF_FFFF, 1'b1},
             {3'd5, 1'b0, 32'd1, 32'hFFFF_FFFF, 1'b0},
             {3'd6, 1'b0, 32'd8, 32'd8, 1'b1},
             {3'd6, 1'b1, 32'h8000_0000, 32'd0, 1'b0},
             {3'd0, 1'b0, 32'd5, 32'd5, 1'b0},
             {3'd3, 1'b0, 32'd3, 32'd7, 1'b1},
             {3'd7, 1'b0, 32'd1, 32'd2, 1'b1} };
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      e = vec[i];
      drive(1'b1, e[68:66], e[65], e[64:33], e[32:1], 32'h40, 16'd0, 1'b0);
      tick();
      checks++; if ({out_valid, taken, mispredict} !== {1'b1, e[0], e[0]}) begin errors++; $display("FAIL cond_%0d: got %0b expected %0b", i, {out_valid, taken, mispredict}, {1'b1, e[0], e[0]}); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_target();
    out_ready = 1'b1;
    drive(1'b1, 3'd7, 1'b0, 32'd0, 32'd0, 32'hFFFF_FFF8, 16'h0001, 1'b1);
    tick();
    checks++; if ({taken, target} !== {1'b1, 32'h0000_0000}) begin errors++; $display("FAIL target_wrap: got %0h expected 100000000", {taken, target}); end
    drive(1'b1, 3'd7, 1'b0, 32'd0, 32'd0, 32'h0000_0100, 16'hFFFE, 1'b1);
    tick();
    checks++; if (target !== 32'h0000_00FC) begin errors++; $display("FAIL target_neg: got %0h expected fc", target); end
    drive(1'b1, 3'd1, 1'b0, 32'd1, 32'd2, 32'h0000_1000, 16'h0010, 1'b0);
    tick();
    checks++; if ({taken, target} !== {1'b0, 32'h0000_1044}) begin errors++; $display("FAIL target_not_taken: got %0h expected 1044", {taken, target}); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] got [$];
    int k = 0;
    for (int c = 0; c < 9; c++) begin
      out_ready = !(c == 1 || c == 2);
      drive(k < 3, 3'd1, 1'b0, 32'd9, 32'd9, 32'h10 * (k + 1), 16'd0, 1'b1);
      #1;
      if (c == 1 || c == 2) begin
        checks++; if ({out_valid, in_ready, target} !== {2'b10, 32'h14}) begin errors++; $display("FAIL bp_hold_c%0d: got %0h expected 200000014", c, {out_valid, in_ready, target}); end
      end
      if (out_valid && out_ready) got.push_back(target);
      if (in_valid && in_ready) k++;
      tick();
    end
    checks++; if (got.size() != 3) begin errors++; $display("FAIL bp_count: got %0d expected 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++; if (got[i] !== 32'h10 * (i + 1) + 32'h4) begin errors++; $display("FAIL bp_order_%0d: got %0h expected %0h", i, got[i], 32'h10 * (i + 1) + 32'h4); end
    end
  endtask

  task automatic test_mispredict();
    out_ready = 1'b1; in_valid = 1'b0; clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    checks++; if ({cnt_branches, cnt_taken, cnt_mispred} !== 12'd0) begin errors++; $display("FAIL clear_cnt: got %0h expected 0", {cnt_branches, cnt_taken, cnt_mispred}); end
    drive(1'b1, 3'd2, 1'b0, 32'd7, 32'd7, 32'd0, 16'd0, 1'b1);
    tick();
    in_valid = 1'b0;
    checks++; if ({out_valid, taken, mispredict, flush} !== 4'b1010) begin errors++; $display("FAIL mp_result: got %0b expected 1010", {out_valid, taken, mispredict, flush}); end
    tick();
    checks++; if ({out_valid, flush} !== 2'b01) begin errors++; $display("FAIL mp_flush: got %0b expected 01", {out_valid, flush}); end
    checks++; if ({cnt_branches, cnt_taken, cnt_mispred} !== {4'd1, 4'd0, 4'd1}) begin errors++; $display("FAIL mp_cnt: got %0h expected 101", {cnt_branches, cnt_taken, cnt_mispred}); end
    tick();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL mp_flush_width: got %0h expected 0", flush); end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0; kill = 1'b1;
    tick();
    kill = 1'b0;
    checks++; if ({out_valid, flush} !== 2'b00) begin errors++; $display("FAIL kill_xfer: got %0b expected 00", {out_valid, flush}); end
    checks++; if ({cnt_branches, cnt_mispred} !== {4'd1, 4'd1}) begin errors++; $display("FAIL kill_cnt: got %0h expected 11", {cnt_branches, cnt_mispred}); end
    in_valid = 1'b1; kill = 1'b1;
    tick();
    in_valid = 1'b0; kill = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL kill_accept: got %0h expected 0", out_valid); end
  endtask

  task automatic test_saturation();
    out_ready = 1'b1; clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    drive(1'b1, 3'd7, 1'b0, 32'd0, 32'd0, 32'd0, 16'd0, 1'b1);
    for (int i = 0; i < 20; i++) tick();
    in_valid = 1'b0;
    tick();
    checks++; if ({cnt_branches, cnt_taken, cnt_mispred} !== {4'd15, 4'd15, 4'd0}) begin errors++; $display("FAIL sat_cnt: got %0h expected ff0", {cnt_branches, cnt_taken, cnt_mispred}); end
    tick();
    checks++; if (cnt_taken !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d expected 15", cnt_taken); end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0; clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    checks++; if ({out_valid, cnt_branches, cnt_taken, cnt_mispred} !== 13'd0) begin errors++; $display("FAIL clear_with_xfer: got %0h expected 0", {out_valid, cnt_branches, cnt_taken, cnt_mispred}); end
  endtask

  initial begin
    test_reset();
    test_signed();
    test_conditions();
    test_target();
    test_back_to_back();
    test_mispredict();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
